// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, holding the fetched
// word for decode until consumed or squashed by a control-flow redirect.
module ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_WIDTH-1:0] redirect_aligned;

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_aligned = redirect_pc & ~DATA_WIDTH'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      instr_q   <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      instr_q   <= instr_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    instr_d   = instr_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          // A response for a squashed fetch (earlier or this cycle) never reaches decode.
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            instr_d   = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + DATA_WIDTH'(4);
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
    if (redirect_valid) begin
      pc_d = redirect_aligned;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign Instr          = instr_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: stimulus pushes expected fetch addresses and
// instructions into queues; a monitor pops and compares as the DUT presents them.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] Instr;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_inst_t;

  logic [31:0] exp_req[$];
  exp_inst_t   exp_inst[$];

  int n_checks = 0;
  int n_pass   = 0;

  ifu #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h8000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .Instr         (Instr),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [31:0] instr, input logic [31:0] pc);
    exp_inst_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_inst.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic vld_prev;
    exp_inst_t e;
    vld_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        vld_prev = 1'b0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          if (exp_req.size() == 0) chk("unexpected_req", imem_req_addr, 32'hFFFF_FFFF);
          else chk("req_addr", imem_req_addr, exp_req.pop_front());
        end
        if (inst_valid && !vld_prev) begin
          if (exp_inst.size() == 0) begin
            chk("unexpected_inst", Instr, 32'hFFFF_FFFF);
          end else begin
            e = exp_inst.pop_front();
            chk("inst_word", Instr, e.instr);
            chk("inst_pc", inst_pc, e.pc);
          end
        end
        vld_prev = inst_valid;
      end
    end
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    tick();
    rst = 1'b0;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Basic fetch and minimum latency
    exp_req.push_back(32'h8000_0000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    push_inst(32'h0050_0093, 32'h8000_0000);
    tick();
    imem_rsp_valid = 1'b0;
    chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);

    // Downstream stall holds the instruction and issues no request
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", Instr, 32'h0050_0093);
      chk("stall_inst_pc", inst_pc, 32'h8000_0000);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("after_consume_valid", {31'd0, inst_valid}, 32'd0);
    chk("next_req_addr", imem_req_addr, 32'h8000_0004);

    // Redirect while waiting drops the in-flight response
    exp_req.push_back(32'h8000_0004);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_instr_kept", Instr, 32'h0050_0093);
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_req_addr", imem_req_addr, 32'h8000_0100);
    tick();
    chk("drop_still_idle", {31'd0, inst_valid}, 32'd0);

    exp_req.push_back(32'h8000_0100);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    push_inst(32'h0000_0013, 32'h8000_0100);
    tick();
    imem_rsp_valid = 1'b0;
    chk("hold2_inst_valid", {31'd0, inst_valid}, 32'd1);

    // Redirect beats a simultaneous consume
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    chk("redir_hold_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_hold_addr", imem_req_addr, 32'h8000_0040);

    // Memory back-pressure with stray responses
    for (int i = 0; i < 10; i++) begin
      imem_rsp_valid = (i % 3 == 1);
      imem_rsp_data  = 32'hBAD0_0000 + i;
      tick();
      chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("bp_req_addr", imem_req_addr, 32'h8000_0040);
      chk("bp_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b0;

    // Asynchronous reset mid-fetch, then a late response
    exp_req.push_back(32'h8000_0040);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("arst_instr", Instr, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'd0);
    chk("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    tick();
    imem_rsp_valid = 1'b0;
    chk("late_rsp_valid", {31'd0, inst_valid}, 32'd0);
    chk("late_rsp_addr", imem_req_addr, 32'h8000_0000);

    exp_req.push_back(32'h8000_0000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0073;
    push_inst(32'h0010_0073, 32'h8000_0000);
    tick();
    imem_rsp_valid = 1'b0;

    // Unaligned redirect to the top word, then wrap to zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("align_addr", imem_req_addr, 32'hFFFF_FFFC);
    exp_req.push_back(32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    push_inst(32'h1234_5678, 32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    exp_req.push_back(32'h0000_0000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    tick();
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("inst_queue_empty", exp_inst.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the address, instruction and PC datapaths.
REQ-002 Parameter RESET_PC, default 32'h8000_0000: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  DATA_WIDTH  fetch address (current PC).
REQ-008 imem_rsp_valid  input  1  fetch data valid this cycle.
REQ-009 imem_rsp_data  input  DATA_WIDTH  fetched instruction word.
REQ-010 inst_valid  output  1  Instr and inst_pc are valid for decode and immediate generation.
REQ-011 inst_ready  input  1  downstream consumes the instruction this cycle.
REQ-012 Instr  output  DATA_WIDTH  held instruction word; feeds the immediate generator directly.
REQ-013 inst_pc  output  DATA_WIDTH  PC of the held instruction.
REQ-014 redirect_valid  input  1  control-flow redirect (branch, jump, trap) this cycle.
REQ-015 redirect_pc  input  DATA_WIDTH  redirect target.

Function
REQ-016 The block SHALL implement a three-state FSM: S_REQ, S_WAIT and S_HOLD.
REQ-017 S_REQ SHALL drive imem_req_valid=1 and imem_req_addr=pc, and SHALL move to S_WAIT on imem_req_ready=1; otherwise it SHALL remain in S_REQ.
REQ-018 S_WAIT SHALL drive imem_req_valid=0 and, on imem_rsp_valid=1, SHALL register Instr<=imem_rsp_data and inst_pc<=pc, then move to S_HOLD.
REQ-019 S_HOLD SHALL drive inst_valid=1, and on inst_ready=1 SHALL set pc<=pc+4 (modulo 2^DATA_WIDTH, wrap 0xFFFF_FFFC->0) and move to S_REQ.
REQ-020 inst_valid SHALL be 1 only in S_HOLD; Instr and inst_pc SHALL be held stable while inst_valid=1 and inst_ready=0.
REQ-021 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.
REQ-022 Minimum latency SHALL be: request cycle N accepted, response at N+1, inst_valid at N+2; best-case throughput is one instruction per 3 cycles.
REQ-023 On redirect_valid=1, pc SHALL load {redirect_pc[DATA_WIDTH-1:2],2'b00} on that edge, overriding the +4 update.
REQ-024 Redirect in S_REQ without acceptance SHALL stay in S_REQ with the new pc; the next request SHALL use the new pc.
REQ-025 Redirect in S_REQ in the same cycle as imem_req_ready=1 SHALL move to S_WAIT with drop flag set; the stale request's address was the old pc.
REQ-026 Redirect in S_WAIT SHALL set the drop flag; the drop flag SHALL NOT be set when the response arrives in that same cycle (that response is discarded directly).
REQ-027 In S_WAIT with the drop flag set, the response SHALL be discarded, Instr and inst_pc SHALL be left unchanged, the drop flag SHALL clear, and the FSM SHALL move to S_REQ.
REQ-028 Redirect in S_HOLD SHALL discard the held instruction and move to S_REQ, with inst_valid=0 from the next cycle; redirect SHALL take priority over a simultaneous inst_ready.
REQ-029 imem_rsp_valid outside S_WAIT SHALL be ignored.

Reset
REQ-030 While rst=1, the block SHALL immediately (asynchronously) set state=S_REQ, pc=RESET_PC, drop=0, Instr=0, inst_pc=0, and inst_valid=0.
REQ-031 imem_req_valid SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding fetch and SHALL NOT later accept its response as an instruction.

Verification
REQ-033 Scenario: release reset, ready=1, rsp next cycle with 0x00500093 -> req_addr=0x80000000, then inst_valid=1, Instr=0x00500093, inst_pc=0x80000000.
REQ-034 Scenario: inst_ready=0 for 5 cycles in S_HOLD -> Instr/inst_pc stable, no new request; inst_ready=1 -> next req_addr=0x80000004.
REQ-035 Scenario: redirect_valid=1 to 0x80000103 in S_WAIT, then rsp 0xDEADBEEF -> response dropped, inst_valid stays 0, next req_addr=0x80000100.
REQ-036 Scenario: redirect and inst_ready in the same S_HOLD cycle, target 0x80000040 -> next request is 0x80000040, not pc+4.
REQ-037 Scenario: imem_req_ready held 0 for 10 cycles -> req_valid stays 1, req_addr stable; rsp_valid pulses in S_REQ are ignored.
REQ-038 Scenario: rst pulse asynchronously in S_WAIT, then late rsp -> outputs reset immediately, pc=0x80000000, the late response is not presented.
